// File: rtl/mfcc_pkg.sv
// Shared constants for the MFCC front end: FFT geometry, sample width and
// the frame buffer's state encoding.
package mfcc_pkg;
  localparam int FFT_N     = 256;
  localparam int FRAME_HOP = 128;
  localparam int SAMPLE_W  = 32;

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_EMIT = 1'b1;

  typedef enum logic {
    S_FILL = ST_FILL,
    S_EMIT = ST_EMIT
  } fo_state_t;
endpackage

// File: rtl/frame_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Read data holds when re is low so the output pipeline can stall on it.
module frame_ram #(
  parameter int DEPTH = 256,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/frame_overlap_f256.sv
// Overlapping frame buffer: collects samples into a circular store and emits
// N-sample frames at a HOP-sample stride as {zero imag, real} FFT words.
module frame_overlap_f256
  import mfcc_pkg::*;
#(
  parameter int N   = FFT_N,
  parameter int HOP = FRAME_HOP,
  parameter int DW  = SAMPLE_W
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [DW-1:0]   s_axis_tdata,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  output logic [2*DW-1:0] m_axis_data_tdata,
  output logic            m_axis_data_tvalid,
  input  logic            m_axis_data_tready,
  output logic            m_axis_data_tlast,
  output logic [15:0]     frame_count
);
  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;

  fo_state_t     state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_base;
  logic [CW-1:0] need_cnt, rd_idx, target;
  logic          first;
  // [0]: RAM read register holds a word, [1]: output register holds a word
  logic [1:0]    vld_pipe;
  logic          last_q;
  logic [DW-1:0] ram_q;
  logic          in_hs, out_hs, out_ld, rd_en, fill_done, frame_done;

  assign in_hs      = s_axis_tvalid && s_axis_tready;
  assign out_hs     = m_axis_data_tvalid && m_axis_data_tready;
  assign out_ld     = !vld_pipe[1] || m_axis_data_tready;
  assign target     = first ? CW'(N) : CW'(HOP);
  assign fill_done  = in_hs && (need_cnt + CW'(1) == target);
  assign frame_done = out_hs && m_axis_data_tlast;
  // A new read is issued only when the RAM register is empty or draining,
  // so the RAM output itself acts as the skid stage during a stall.
  assign rd_en      = (state == S_EMIT) && (rd_idx != CW'(N)) &&
                      (!vld_pipe[0] || out_ld);

  assign m_axis_data_tvalid = vld_pipe[1];

  frame_ram #(.DEPTH(N), .DW(DW), .AW(AW)) u_ram (
    .clk   (aclk),
    .we    (in_hs),
    .waddr (wr_ptr),
    .wdata (s_axis_tdata),
    .re    (rd_en),
    .raddr (rd_base + rd_idx[AW-1:0]),
    .rdata (ram_q)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (fill_done)  state_nxt = S_EMIT;
      S_EMIT:  if (frame_done) state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state             <= S_FILL;
      wr_ptr            <= '0;
      rd_base           <= '0;
      need_cnt          <= '0;
      rd_idx            <= '0;
      first             <= 1'b1;
      vld_pipe          <= '0;
      last_q            <= 1'b0;
      s_axis_tready     <= 1'b0;
      m_axis_data_tdata <= '0;
      m_axis_data_tlast <= 1'b0;
      frame_count       <= '0;
    end else begin
      state         <= state_nxt;
      s_axis_tready <= (state_nxt == S_FILL);
      if (in_hs) begin
        wr_ptr   <= wr_ptr + AW'(1);
        need_cnt <= need_cnt + CW'(1);
      end
      if (fill_done) first <= 1'b0;
      if (rd_en) begin
        rd_idx <= rd_idx + CW'(1);
        last_q <= (rd_idx == CW'(N - 1));
      end
      vld_pipe[0] <= rd_en || (vld_pipe[0] && !out_ld);
      if (out_ld) begin
        vld_pipe[1]       <= vld_pipe[0];
        m_axis_data_tlast <= vld_pipe[0] && last_q;
        if (vld_pipe[0]) m_axis_data_tdata <= {{DW{1'b0}}, ram_q};
      end
      if (frame_done) begin
        rd_base     <= rd_base + AW'(HOP);
        need_cnt    <= '0;
        rd_idx      <= '0;
        frame_count <= frame_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_frame_overlap_f256.sv
// Self-checking bench for frame_overlap_f256: frames are predicted from the
// list of accepted samples (frame k = samples k*HOP .. k*HOP+N-1).
module tb_frame_overlap_f256;
  localparam int N   = 256;
  localparam int HOP = 128;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_d;
  logic        s_v, s_rdy;
  logic [63:0] m_d;
  logic        m_v, m_r, m_l;
  logic [15:0] fc;

  always #5 aclk = ~aclk;

  frame_overlap_f256 dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_tdata       (s_d),
    .s_axis_tvalid      (s_v),
    .s_axis_tready      (s_rdy),
    .m_axis_data_tdata  (m_d),
    .m_axis_data_tvalid (m_v),
    .m_axis_data_tready (m_r),
    .m_axis_data_tlast  (m_l),
    .frame_count        (fc)
  );

  int          n_chk = 0, n_bad = 0;
  logic [31:0] src [$];
  logic [31:0] acc [$];
  int          src_idx, n_out, cyc, fill_step, rise_step;
  logic        prev_v, prev_r, prev_l, end_pend;
  logic [63:0] prev_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input int vmode, input int rmode);
    int f, p, idx;
    logic [31:0] e;
    if (end_pend) begin
      chk("tvalid_fall", 64'(m_v), 64'd0);
      chk("tready_back", 64'(s_rdy), 64'd1);
      end_pend = 1'b0;
    end
    if (prev_v && !prev_r) begin
      chk("stall_valid", 64'(m_v), 64'd1);
      chk("stall_data", m_d, prev_d);
      chk("stall_last", 64'(m_l), 64'(prev_l));
    end
    if (m_v) chk("tready_in_emit", 64'(s_rdy), 64'd0);
    chk("frame_count", 64'(fc), 64'(n_out / N));
    if (m_v && !prev_v && fill_step >= 0) begin
      // fill handshake at the edge ending step c; tvalid two edges later is seen in step c+3
      chk("vld_latency", 64'(cyc - fill_step), 64'd3);
      fill_step = -1;
      rise_step = cyc;
    end

    s_v = (src_idx < src.size()) &&
          (vmode == 0 || (vmode == 1 && cyc % 3 == 0) ||
           (vmode == 2 && $urandom_range(1, 0) == 1));
    s_d = s_v ? src[src_idx] : $urandom;
    m_r = (rmode == 0) ? 1'b1 : 1'($urandom_range(1, 0));

    if (s_v && s_rdy) begin
      acc.push_back(s_d);
      src_idx++;
      if (acc.size() >= N && (acc.size() - N) % HOP == 0) fill_step = cyc;
    end
    if (m_v && m_r) begin
      f = n_out / N;
      p = n_out % N;
      idx = f * HOP + p;
      chk("out_before_in", 64'(idx < acc.size()), 64'd1);
      e = (idx < acc.size()) ? acc[idx] : 32'hDEAD_BEEF;
      chk("tdata", m_d, {32'h0, e});
      chk("tlast", 64'(m_l), 64'(p == N - 1));
      if (p == N - 1) begin
        end_pend = 1'b1;
        if (rmode == 0) chk("back_to_back", 64'(cyc - rise_step), 64'(N - 1));
      end
      n_out++;
    end
    prev_v = m_v; prev_r = m_r; prev_d = m_d; prev_l = m_l;
    @(posedge aclk);
    @(negedge aclk);
    cyc++;
  endtask

  task automatic run(input int vmode, input int rmode, input int goal_fc, input int stop_out);
    int budget;
    budget = 30000;
    while (budget > 0 &&
           (end_pend || (stop_out > 0 ? n_out < stop_out : n_out < goal_fc * N))) begin
      step(vmode, rmode);
      budget--;
    end
    if (stop_out == 0) begin
      chk("out_count", 64'(n_out), 64'(goal_fc * N));
      chk("frame_count_end", 64'(fc), 64'(goal_fc));
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    s_v = 1'b0;
    m_r = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk("rst_s_tready", 64'(s_rdy), 64'd0);
    chk("rst_m_tvalid", 64'(m_v), 64'd0);
    chk("rst_m_tlast", 64'(m_l), 64'd0);
    chk("rst_m_tdata", m_d, 64'd0);
    chk("rst_frame_count", 64'(fc), 64'd0);
    aresetn = 1'b1;
    acc.delete();
    src.delete();
    src_idx = 0; n_out = 0; fill_step = -1; rise_step = 0;
    prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = '0; end_pend = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk("tready_after_reset", 64'(s_rdy), 64'd1);
  endtask

  initial begin
    aresetn = 1'b0; s_v = 1'b0; s_d = '0; m_r = 1'b0; cyc = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);

    // ramp 0..383: frame 0 then frame 1, always ready
    do_reset();
    for (int i = 0; i < 384; i++) src.push_back(32'(i));
    run(0, 0, 1, 0);
    run(0, 0, 2, 0);

    // 1024-sample ramp with random output backpressure
    do_reset();
    for (int i = 0; i < 1024; i++) src.push_back(32'(i));
    run(0, 1, 7, 0);

    // input valid one cycle in three
    do_reset();
    for (int i = 0; i < 256; i++) src.push_back(32'(i));
    run(1, 0, 1, 0);

    // reset after output word 100, then a fresh fill of 1000..1255
    do_reset();
    for (int i = 0; i < 256; i++) src.push_back(32'(i));
    run(0, 0, 1, 101);
    do_reset();
    for (int i = 1000; i < 1256; i++) src.push_back(32'(i));
    run(0, 0, 1, 0);

    // random data with NaN and -0.0 patterns, random gaps and backpressure
    do_reset();
    for (int i = 0; i < 384; i++) src.push_back($urandom);
    src[37]  = 32'h7FC0_0000;
    src[200] = 32'h8000_0000;
    src[300] = 32'h7FC0_0000;
    run(2, 1, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/frame_overlap_f256.md
# frame_overlap_f256

Overlapping frame buffer that sits directly upstream of the 256-point floating-point FFT in the MFCC front end. It accepts a continuous stream of IEEE-754 single-precision audio samples and emits 256-sample frames at a 128-sample hop (50 % overlap). Each frame is formatted as the FFT's 64-bit complex input, with the real part in the low word and the imaginary part zero, and tlast marks the final sample. It performs no arithmetic. Windowing is a separate stage.

## Interface
Parameters:
- N, 256: frame length in samples. Power of two.
- HOP, 128: hop in samples. Power of two, HOP ≤ N.
- DW, 32: sample width (float32 bit pattern).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset. Synchronous, active-low.
- s_axis_tdata  in  DW  input sample (float32 bits, passed through untouched).
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  block can accept a sample.
- m_axis_data_tdata  out  2·DW  {DW'b0 imag, sample real}; feeds FFT s_axis_data_tdata.
- m_axis_data_tvalid  out  1  output word valid.
- m_axis_data_tready  in  1  FFT ready.
- m_axis_data_tlast  out  1  high on word N-1 of each frame only.
- frame_count  out  16  frames completely emitted since reset. Wraps at 2^16.

## Operation
- Storage is a circular buffer of N words with write pointer wr_ptr and frame start pointer rd_base, both log2(N) bits with natural wrap.
- Frame k holds input samples k·HOP … k·HOP+N-1, in stream order.
- FSM states:
  - FILL: s_axis_tready = 1. Each input handshake writes buf[wr_ptr] and increments wr_ptr and need_cnt. When the handshake brings need_cnt to its target, go to EMIT. Target is N for the first frame after reset and HOP afterwards.
  - EMIT: s_axis_tready = 0. Read N words starting at rd_base, wrapping. Each output handshake advances the read index. Exit when the handshake of word N-1 completes: rd_base += HOP, need_cnt = 0, frame_count++, go to FILL.
- Input is never accepted during EMIT. Upstream absorbs the stall.
- Gaps in s_axis_tvalid only delay the frame. Frame contents are independent of input timing.
- Output bits [2·DW-1:DW] are always zero.

## Timing
- Reset values: s_axis_tready = 0, m_axis_data_tvalid = 0, m_axis_data_tlast = 0, m_axis_data_tdata = 0, frame_count = 0. Internally, state = FILL, wr_ptr = rd_base = need_cnt = 0, and the first-frame flag is set.
- s_axis_tready goes to 1 on the first rising edge with aresetn high.
- RAM read latency is 1 cycle. m_axis_data_tvalid asserts exactly 2 rising edges after the input handshake that completes the fill.
- With m_axis_data_tready held high, the block emits one word per cycle: N words in N consecutive cycles.
- While tvalid=1 and tready=0, tdata and tlast hold stable. No word is dropped or duplicated. This requires a prefetch or skid register, because the RAM read must not advance on a stall.
- m_axis_data_tvalid falls on the cycle after the word N-1 handshake.
- s_axis_tready returns to 1 on that same cycle.
- Steady-state frame period is HOP input cycles + N output cycles + 2.
- If aresetn goes low during either state, the block drops all buffered data at the next edge, returns to reset values, and requires a full N-sample fill again. No partial frame or tlast is emitted after reset.
- An input handshake and the last output handshake can never coincide, because tready is 0 in EMIT.

## Structure
- Shared package (mfcc_pkg): FFT_N = 256, FRAME_HOP = 128, SAMPLE_W = 32, state encoding localparams.
- Sub-module frame_ram: simple dual-port RAM, N×DW, 1 write port, 1 registered read port, no reset on contents. The top level holds the FSM, pointers, skid register and frame_count.

## Test plan
- Ramp 0…255 (integer bit patterns), tready=1 → exactly 256 output words with tdata[31:0] = 0…255, tdata[63:32] = 0, tlast only on value 255, frame_count = 1, first tvalid 2 edges after input 255 accepted.
- Continue ramp 256…383 → frame 1 = 128…383, tlast on 383, frame_count = 2, s_axis_tready = 0 throughout the emission.
- Ramp of 1024 samples with m_axis_data_tready randomly toggling about 50 % → frames k = 0…6 each equal k·128 … k·128+255, with tdata and tlast stable across every stall.
- Input tvalid asserted 1 cycle in 3 → identical frame contents to scenario 1, with only timing changed.
- aresetn low for 1 cycle after output word 100 of frame 0 → all outputs at reset values next cycle. Feeding 256 new samples (1000…1255) gives a frame of exactly 1000…1255, frame_count = 1.
- Sample 0x7FC00000 (NaN) and 0x80000000 (-0.0) in the stream → emitted bit-exact at their frame positions.
